// File: rtl/tlb_mp.sv
// tlb_mp: NPORT-search joint TLB with Random/Wired replacement and sequential flush sweep.
// Define TLB_MULTIHIT_EN to report multiple matches on s_multi (tied to 0 otherwise).
module tlb_mp #(
  parameter int TLBNUM = 32,
  parameter int NPORT = 2,
  parameter int ASID_W = 8,
  parameter int PFN_W = 20,
  localparam int IDX_W = $clog2(TLBNUM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORT-1:0]        s_req,
  input  logic [NPORT*19-1:0]     s_vpn2,
  input  logic [NPORT-1:0]        s_odd,
  input  logic [NPORT*ASID_W-1:0] s_asid,
  output logic [NPORT-1:0]        s_valid,
  output logic [NPORT-1:0]        s_found,
  output logic [NPORT*IDX_W-1:0]  s_index,
  output logic [NPORT*PFN_W-1:0]  s_pfn,
  output logic [NPORT*3-1:0]      s_c,
  output logic [NPORT-1:0]        s_d,
  output logic [NPORT-1:0]        s_v,
  output logic [NPORT-1:0]        s_multi,
  input  logic                    we,
  input  logic                    we_rand,
  input  logic [IDX_W-1:0]        w_index,
  input  logic [18:0]             w_vpn2,
  input  logic [ASID_W-1:0]       w_asid,
  input  logic                    w_g,
  input  logic [PFN_W-1:0]        w_pfn0,
  input  logic [2:0]              w_c0,
  input  logic                    w_d0,
  input  logic                    w_v0,
  input  logic [PFN_W-1:0]        w_pfn1,
  input  logic [2:0]              w_c1,
  input  logic                    w_d1,
  input  logic                    w_v1,
  input  logic                    wired_we,
  input  logic [IDX_W-1:0]        wired_in,
  output logic [IDX_W-1:0]        random,
  input  logic [IDX_W-1:0]        r_index,
  output logic                    r_e,
  output logic [18:0]             r_vpn2,
  output logic [ASID_W-1:0]       r_asid,
  output logic                    r_g,
  output logic [PFN_W-1:0]        r_pfn0,
  output logic [2:0]              r_c0,
  output logic                    r_d0,
  output logic                    r_v0,
  output logic [PFN_W-1:0]        r_pfn1,
  output logic [2:0]              r_c1,
  output logic                    r_d1,
  output logic                    r_v1,
  input  logic                    flush_req,
  input  logic                    flush_asid_mode,
  input  logic [ASID_W-1:0]       flush_asid,
  output logic                    flush_busy,
  output logic                    flush_done
);
  typedef struct packed {
    logic [18:0]       vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W-1:0]  pfn0;
    logic [2:0]        c0;
    logic              d0;
    logic              v0;
    logic [PFN_W-1:0]  pfn1;
    logic [2:0]        c1;
    logic              d1;
    logic              v1;
  } ent_t;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  localparam logic [IDX_W-1:0] MAX = IDX_W'(TLBNUM - 1);
  ent_t              r_tlb [TLBNUM];
  logic [TLBNUM-1:0] r_exist;
  logic [IDX_W-1:0]  r_random, r_wired, r_ptr;
  logic              r_fmode;
  logic [ASID_W-1:0] r_fasid;
  state_t            r_state;
  logic              w_wr;
  logic [IDX_W-1:0]  w_widx;
  ent_t              w_new, w_rd;
  logic [TLBNUM-1:0] w_m [NPORT];
  logic [NPORT-1:0]  w_hit;
  logic [IDX_W-1:0]  w_hidx [NPORT];
  assign w_wr   = (we | we_rand) & ~flush_busy;
  assign w_widx = we ? w_index : r_random;
  assign w_new  = {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1};
  assign w_rd   = r_tlb[r_index];
  assign r_e    = r_exist[r_index];
  assign {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} = w_rd;
  assign random = r_random;
  // Descending scan so the lowest matching index is the last assignment and wins.
  always_comb begin
    w_hit = '0;
    for (int p = 0; p < NPORT; p++) begin
      w_hidx[p] = '0;
      for (int i = 0; i < TLBNUM; i++)
        w_m[p][i] = r_exist[i] && r_tlb[i].vpn2 == s_vpn2[p*19+:19] &&
                    (r_tlb[i].asid == s_asid[p*ASID_W+:ASID_W] || r_tlb[i].g);
      for (int i = TLBNUM - 1; i >= 0; i--)
        if (w_m[p][i]) begin
          w_hit[p]  = 1'b1;
          w_hidx[p] = IDX_W'(i);
        end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s_valid <= '0;
      s_found <= '0;
      s_index <= '0;
      s_pfn   <= '0;
      s_c     <= '0;
      s_d     <= '0;
      s_v     <= '0;
    end else begin
      s_valid <= s_req;
      for (int p = 0; p < NPORT; p++)
        if (s_req[p]) begin
          s_found[p]               <= w_hit[p];
          s_index[p*IDX_W+:IDX_W]  <= w_hidx[p];
          s_pfn[p*PFN_W+:PFN_W]    <= !w_hit[p] ? '0 : s_odd[p] ? r_tlb[w_hidx[p]].pfn1 : r_tlb[w_hidx[p]].pfn0;
          s_c[p*3+:3]              <= !w_hit[p] ? '0 : s_odd[p] ? r_tlb[w_hidx[p]].c1 : r_tlb[w_hidx[p]].c0;
          s_d[p]                   <= w_hit[p] && (s_odd[p] ? r_tlb[w_hidx[p]].d1 : r_tlb[w_hidx[p]].d0);
          s_v[p]                   <= w_hit[p] && (s_odd[p] ? r_tlb[w_hidx[p]].v1 : r_tlb[w_hidx[p]].v0);
        end
    end
  end
`ifdef TLB_MULTIHIT_EN
  logic [IDX_W:0]   w_cnt [NPORT];
  logic [NPORT-1:0] r_multi;
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      w_cnt[p] = '0;
      for (int i = 0; i < TLBNUM; i++) w_cnt[p] = w_cnt[p] + (IDX_W+1)'(w_m[p][i]);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) r_multi <= '0;
    else for (int p = 0; p < NPORT; p++) if (s_req[p]) r_multi[p] <= w_cnt[p] > (IDX_W+1)'(1);
  end
  assign s_multi = r_multi;
`else
  assign s_multi = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < TLBNUM; i++) r_tlb[i] <= '0;
    else if (w_wr) r_tlb[w_widx] <= w_new;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_random <= MAX;
      r_wired  <= '0;
    end else begin
      if (wired_we && !flush_busy) r_wired <= wired_in;
      r_random <= (wired_we && !flush_busy) || r_random == r_wired || r_random == '0 ? MAX : r_random - IDX_W'(1);
    end
  end
  // Writes are blocked while sweeping, so set and clear of exist bits never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_exist    <= '0;
      r_ptr      <= '0;
      r_fmode    <= 1'b0;
      r_fasid    <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (w_wr) r_exist[w_widx] <= 1'b1;
      case (r_state)
        IDLE: if (flush_req) begin
          r_fmode    <= flush_asid_mode;
          r_fasid    <= flush_asid;
          r_ptr      <= '0;
          r_state    <= SWEEP;
          flush_busy <= 1'b1;
        end
        SWEEP: begin
          if (!r_fmode || (!r_tlb[r_ptr].g && r_tlb[r_ptr].asid == r_fasid)) r_exist[r_ptr] <= 1'b0;
          r_ptr <= r_ptr + IDX_W'(1);
          if (r_ptr == MAX) begin
            r_state    <= DONE;
            flush_busy <= 1'b0;
            flush_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tlb_mp.sv
// tb_tlb_mp: directed and random stimulus for tlb_mp against an entry-table reference model.
module tb_tlb_mp;
  localparam int N = 32, P = 2, A = 8, F = 20, IW = 5;
  typedef struct packed {
    logic [18:0]  vpn2;
    logic [A-1:0] asid;
    logic         g;
    logic [F-1:0] pfn0;
    logic [2:0]   c0;
    logic         d0, v0;
    logic [F-1:0] pfn1;
    logic [2:0]   c1;
    logic         d1, v1;
  } ent_t;
  logic clk = 0, reset = 1;
  logic [P-1:0] s_req = '0, s_odd = '0, s_valid, s_found, s_d, s_v, s_multi;
  logic [P*19-1:0] s_vpn2 = '0;
  logic [P*A-1:0] s_asid = '0;
  logic [P*IW-1:0] s_index;
  logic [P*F-1:0] s_pfn;
  logic [P*3-1:0] s_c;
  logic we = 0, we_rand = 0, w_g = 0, w_d0 = 0, w_v0 = 0, w_d1 = 0, w_v1 = 0;
  logic [IW-1:0] w_index = '0, wired_in = '0, random, r_index = '0;
  logic [18:0] w_vpn2 = '0, r_vpn2;
  logic [A-1:0] w_asid = '0, r_asid, flush_asid = '0;
  logic [F-1:0] w_pfn0 = '0, w_pfn1 = '0, r_pfn0, r_pfn1;
  logic [2:0] w_c0 = '0, w_c1 = '0, r_c0, r_c1;
  logic wired_we = 0, r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic flush_req = 0, flush_asid_mode = 0, flush_busy, flush_done;
  int n_vec = 0, n_err = 0;
  ent_t m_ent [N];
  logic [N-1:0] m_e;
  int m_rand, m_wired, m_fleft, m_fptr, m_fasid;
  bit m_done, m_fmode;
  logic [31:0] e_valid [P], e_found [P], e_idx [P], e_pfn [P], e_c [P], e_d [P], e_v [P], e_multi [P];

  tlb_mp dut (.clk(clk), .reset(reset), .s_req(s_req), .s_vpn2(s_vpn2), .s_odd(s_odd), .s_asid(s_asid),
    .s_valid(s_valid), .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d),
    .s_v(s_v), .s_multi(s_multi), .we(we), .we_rand(we_rand), .w_index(w_index), .w_vpn2(w_vpn2),
    .w_asid(w_asid), .w_g(w_g), .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1), .wired_we(wired_we), .wired_in(wired_in),
    .random(random), .r_index(r_index), .r_e(r_e), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0), .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1),
    .r_v1(r_v1), .flush_req(flush_req), .flush_asid_mode(flush_asid_mode), .flush_asid(flush_asid),
    .flush_busy(flush_busy), .flush_done(flush_done));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < N; i++) m_ent[i] = '0;
    m_e = '0; m_rand = N - 1; m_wired = 0; m_fleft = 0; m_fptr = 0; m_done = 0; m_fmode = 0; m_fasid = 0;
    for (int p = 0; p < P; p++) begin
      e_valid[p] = 0; e_found[p] = 0; e_idx[p] = 0; e_pfn[p] = 0; e_c[p] = 0; e_d[p] = 0; e_v[p] = 0; e_multi[p] = 0;
    end
  endtask

  // Advance the reference model by one clock using the inputs currently applied.
  task automatic step_model();
    bit busy;
    int idx, hits;
    bit done_n;
    busy = m_fleft > 0;
    for (int p = 0; p < P; p++) begin
      e_valid[p] = 32'(s_req[p]);
      if (s_req[p]) begin
        hits = 0;
        e_found[p] = 0; e_idx[p] = 0; e_pfn[p] = 0; e_c[p] = 0; e_d[p] = 0; e_v[p] = 0;
        for (int i = 0; i < N; i++)
          if (m_e[i] && m_ent[i].vpn2 == s_vpn2[p*19+:19] && (m_ent[i].asid == s_asid[p*A+:A] || m_ent[i].g)) begin
            if (hits == 0) begin
              e_found[p] = 1; e_idx[p] = i;
              e_pfn[p] = s_odd[p] ? 32'(m_ent[i].pfn1) : 32'(m_ent[i].pfn0);
              e_c[p]   = s_odd[p] ? 32'(m_ent[i].c1) : 32'(m_ent[i].c0);
              e_d[p]   = s_odd[p] ? 32'(m_ent[i].d1) : 32'(m_ent[i].d0);
              e_v[p]   = s_odd[p] ? 32'(m_ent[i].v1) : 32'(m_ent[i].v0);
            end
            hits++;
          end
`ifdef TLB_MULTIHIT_EN
        e_multi[p] = 32'(hits > 1);
`else
        e_multi[p] = 0;
`endif
      end
    end
    if (!busy && (we || we_rand)) begin
      idx = we ? int'(w_index) : m_rand;
      m_ent[idx].vpn2 = w_vpn2; m_ent[idx].asid = w_asid; m_ent[idx].g = w_g;
      m_ent[idx].pfn0 = w_pfn0; m_ent[idx].c0 = w_c0; m_ent[idx].d0 = w_d0; m_ent[idx].v0 = w_v0;
      m_ent[idx].pfn1 = w_pfn1; m_ent[idx].c1 = w_c1; m_ent[idx].d1 = w_d1; m_ent[idx].v1 = w_v1;
      m_e[idx] = 1;
    end
    done_n = 0;
    if (busy) begin
      if (!m_fmode || (!m_ent[m_fptr].g && int'(m_ent[m_fptr].asid) == m_fasid)) m_e[m_fptr] = 0;
      m_fptr++; m_fleft--;
      done_n = m_fleft == 0;
    end else if (!m_done && flush_req) begin
      m_fleft = N; m_fptr = 0; m_fmode = flush_asid_mode; m_fasid = int'(flush_asid);
    end
    m_done = done_n;
    if (!busy && wired_we) begin
      m_wired = int'(wired_in); m_rand = N - 1;
    end else m_rand = (m_rand == m_wired || m_rand == 0) ? N - 1 : m_rand - 1;
  endtask

  task automatic cyc();
    step_model();
    @(posedge clk); #1;
    for (int p = 0; p < P; p++) begin
      chk("s_valid", 64'(s_valid[p]), 64'(e_valid[p]));
      chk("s_found", 64'(s_found[p]), 64'(e_found[p]));
      chk("s_index", 64'(s_index[p*IW+:IW]), 64'(e_idx[p]));
      chk("s_pfn", 64'(s_pfn[p*F+:F]), 64'(e_pfn[p]));
      chk("s_c", 64'(s_c[p*3+:3]), 64'(e_c[p]));
      chk("s_d", 64'(s_d[p]), 64'(e_d[p]));
      chk("s_v", 64'(s_v[p]), 64'(e_v[p]));
      chk("s_multi", 64'(s_multi[p]), 64'(e_multi[p]));
    end
    chk("random", 64'(random), 64'(m_rand));
    chk("flush_busy", 64'(flush_busy), 64'(m_fleft > 0));
    chk("flush_done", 64'(flush_done), 64'(m_done));
    s_req = '0; we = 0; we_rand = 0; wired_we = 0; flush_req = 0;
    r_index = IW'($urandom_range(N - 1)); #1;
    chk("r_e", 64'(r_e), 64'(m_e[r_index]));
    chk("r_vpn2", 64'(r_vpn2), 64'(m_ent[r_index].vpn2));
    chk("r_asid", 64'(r_asid), 64'(m_ent[r_index].asid));
    chk("r_g", 64'(r_g), 64'(m_ent[r_index].g));
    chk("r_pfn1", 64'(r_pfn1), 64'(m_ent[r_index].pfn1));
    chk("r_c0", 64'(r_c0), 64'(m_ent[r_index].c0));
  endtask

  task automatic wr(input int idx, input int vpn2, input int asid, input bit g, input int pfn1, input bit v1);
    we = 1; w_index = IW'(idx); w_vpn2 = 19'(vpn2); w_asid = A'(asid); w_g = g; w_pfn1 = F'(pfn1); w_v1 = v1;
    w_pfn0 = F'($urandom); w_c0 = 3'($urandom); w_d0 = 1'($urandom); w_v0 = 1'($urandom);
    w_c1 = 3'($urandom); w_d1 = 1'($urandom);
  endtask

  task automatic srch(input int p, input int vpn2, input int asid, input bit odd);
    s_req[p] = 1; s_vpn2[p*19+:19] = 19'(vpn2); s_asid[p*A+:A] = A'(asid); s_odd[p] = odd;
  endtask

  task automatic do_reset();
    reset = 1; s_req = '0; we = 0; we_rand = 0; wired_we = 0; flush_req = 0;
    repeat (2) @(posedge clk);
    #1;
    model_init();
    chk("rst_valid", 64'(s_valid), 0);
    chk("rst_found", 64'(s_found), 0);
    chk("rst_pfn", 64'(s_pfn), 0);
    chk("rst_random", 64'(random), N - 1);
    chk("rst_busy", 64'(flush_busy), 0);
    chk("rst_done", 64'(flush_done), 0);
    for (int i = 0; i < N; i++) begin
      r_index = IW'(i); #0.1;
      chk("rst_r_e", 64'(r_e), 0);
    end
    reset = 0;
  endtask

  initial begin
    int nb, r;
    do_reset();
    srch(0, 0, 0, 0); srch(1, 0, 0, 0); cyc();
    chk("t1_valid", 64'(s_valid), 3);
    chk("t1_found", 64'(s_found), 0);
    chk("t1_index", 64'(s_index), 0);
    wr(5, 'h12345, 3, 0, 'hABCDE, 1); cyc();
    srch(0, 'h12345, 3, 1); srch(1, 'h12345, 4, 1); cyc();
    chk("t2_found", 64'(s_found), 1);
    chk("t2_index", 64'(s_index[IW-1:0]), 5);
    chk("t2_pfn", 64'(s_pfn[F-1:0]), 'hABCDE);
    chk("t2_v", 64'(s_v[0]), 1);
    wr(5, 'h12345, 3, 1, 'hABCDE, 1); cyc();
    srch(1, 'h12345, 4, 1); cyc();
    chk("t2_global", 64'(s_found[1]), 1);
    wr(7, 'h0BEEF, 1, 0, 'h77777, 1); srch(0, 'h0BEEF, 1, 1); cyc();
    chk("t3_same", 64'(s_found[0]), 0);
    srch(0, 'h0BEEF, 1, 1); cyc();
    chk("t3_next", 64'(s_found[0]), 1);
    chk("t3_idx", 64'(s_index[IW-1:0]), 7);
    wired_we = 1; wired_in = 28; cyc();
    chk("t4_r31", 64'(random), 31);
    cyc();
    chk("t4_r30", 64'(random), 30);
    wr(0, 'h2A, 0, 0, 'h2A2A, 1); we = 0; we_rand = 1; cyc();
    chk("t4_r29", 64'(random), 29);
    r_index = 30; #1;
    chk("t4_wr30_e", 64'(r_e), 1);
    chk("t4_wr30", 64'(r_vpn2), 'h2A);
    cyc();
    chk("t4_r28", 64'(random), 28);
    cyc();
    chk("t4_wrap", 64'(random), 31);
    wired_we = 1; wired_in = 31; cyc(); cyc(); cyc();
    chk("t4_hold", 64'(random), 31);
    wired_we = 1; wired_in = 4; cyc();
    for (int i = 0; i < 4; i++) begin
      wr(i, 'h100 + i, 3, i == 2, 'h200 + i, 1); cyc();
    end
    flush_req = 1; flush_asid_mode = 1; flush_asid = 3; cyc();
    nb = 0;
    while (flush_busy && nb < 40) begin
      if (nb == 10) wr(1, 'h101, 3, 0, 'h999, 1);
      cyc();
      nb++;
    end
    chk("t5_len", 64'(nb), N);
    chk("t5_done", 64'(flush_done), 1);
    srch(0, 'h102, 3, 1); srch(1, 'h100, 3, 1); cyc();
    chk("t5_found", 64'(s_found), 1);
    srch(0, 'h101, 3, 1); srch(1, 'h103, 3, 1); cyc();
    chk("t5_gone", 64'(s_found), 0);
    wr(4, 'h3333, 6, 0, 'h44, 1); cyc();
    wr(9, 'h3333, 6, 0, 'h99, 1); cyc();
    srch(0, 'h3333, 6, 1); cyc();
    chk("t6_found", 64'(s_found[0]), 1);
    chk("t6_idx", 64'(s_index[IW-1:0]), 4);
    for (int k = 0; k < 2500; k++) begin
      for (int p = 0; p < P; p++)
        if ($urandom_range(1) == 1) srch(p, $urandom_range(7), $urandom_range(3), 1'($urandom_range(1)));
      r = $urandom_range(99);
      if (r < 15) wr($urandom_range(N - 1), $urandom_range(7), $urandom_range(3), $urandom_range(3) == 0, $urandom, 1'($urandom));
      else if (r < 20) begin
        wr(0, $urandom_range(7), $urandom_range(3), $urandom_range(3) == 0, $urandom, 1'($urandom));
        we = 0; we_rand = 1;
      end else if (r == 20) begin
        flush_req = 1; flush_asid_mode = 1'($urandom_range(1)); flush_asid = A'($urandom_range(3));
      end else if (r == 21) begin
        wired_we = 1; wired_in = IW'($urandom_range(N - 1));
      end
      cyc();
    end
    flush_req = 1; flush_asid_mode = 0; cyc();
    repeat (5) cyc();
    do_reset();
    srch(0, 'h3333, 6, 0); cyc();
    chk("t7_miss", 64'(s_found[0]), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
